// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM command-port arbiter: channel ids, command word, FSM states.
package sdram_arbiter_pkg;

    localparam int SDRAM_ADDR_BITS = 23;
    localparam int SDRAM_DATA_BITS = 16;

    typedef enum logic [1:0] {
        CH_PRG  = 2'd0,
        CH_CHR  = 2'd1,
        CH_HOST = 2'd2,
        CH_REF  = 2'd3
    } sdram_ch_t;

    typedef struct packed {
        logic                       refresh;
        logic                       we;
        logic [SDRAM_ADDR_BITS-1:0] addr;
        logic [SDRAM_DATA_BITS-1:0] wdata;
        logic [1:0]                 wmask;
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_refresh_scheduler.sv
// Refresh credit generator: one credit every REFRESH_INT cycles, debt saturates at DEBT_MAX.
// A completed refresh pays back one credit; a credit and a payback in the same cycle cancel.
module sdram_arbiter_refresh_scheduler #(
    parameter int REFRESH_INT = 780,
    parameter int DEBT_MAX    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    output logic [3:0] debt,
    output logic       pending,
    output logic       urgent
);

    localparam int                  CNT_BITS = $clog2(REFRESH_INT);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(REFRESH_INT - 1);
    localparam logic [3:0]          DEBT_TOP = 4'(DEBT_MAX);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]          debt_q, debt_d;
    logic                credit;

    always_comb begin
        credit = (cnt_q == CNT_LAST);
        cnt_d  = credit ? '0 : cnt_q + CNT_BITS'(1);
        debt_d = debt_q;
        if (credit && !done) begin
            if (debt_q != DEBT_TOP) debt_d = debt_q + 4'd1;
        end else if (done && !credit) begin
            if (debt_q != 4'd0) debt_d = debt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            debt_q <= 4'd0;
        end else begin
            cnt_q  <= cnt_d;
            debt_q <= debt_d;
        end
    end

    assign debt    = debt_q;
    assign pending = (debt_q != 4'd0);
    assign urgent  = (debt_q == DEBT_TOP);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM command port between PRG, CHR, HOST and refresh; one command in flight.
// Fixed priority with refresh debt; req->cmd_valid 1 cycle, ack 1 cycle after rsp_valid.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS   = SDRAM_ADDR_BITS,
    parameter int DATA_BITS   = SDRAM_DATA_BITS,
    parameter int REFRESH_INT = 780,
    parameter int DEBT_MAX    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prg_req,
    input  logic [ADDR_BITS-1:0] prg_addr,
    input  logic                 prg_we,
    input  logic [DATA_BITS-1:0] prg_wdata,
    input  logic [1:0]           prg_wmask,
    output logic                 prg_ack,
    output logic [DATA_BITS-1:0] prg_rdata,
    input  logic                 chr_req,
    input  logic [ADDR_BITS-1:0] chr_addr,
    input  logic                 chr_we,
    input  logic [DATA_BITS-1:0] chr_wdata,
    input  logic [1:0]           chr_wmask,
    output logic                 chr_ack,
    output logic [DATA_BITS-1:0] chr_rdata,
    input  logic                 host_req,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic                 host_we,
    input  logic [DATA_BITS-1:0] host_wdata,
    input  logic [1:0]           host_wmask,
    output logic                 host_ack,
    output logic [DATA_BITS-1:0] host_rdata,
    input  logic                 refresh_hint,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_refresh,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic                 cmd_we,
    output logic [DATA_BITS-1:0] cmd_wdata,
    output logic [1:0]           cmd_wmask,
    input  logic                 rsp_valid,
    input  logic [DATA_BITS-1:0] rsp_rdata,
    output logic [3:0]           refresh_debt
);

    arb_state_t           state_q, state_d;
    sdram_ch_t            owner_q, owner_d;
    sdram_cmd_t           cmd_q, cmd_d;
    logic [2:0]           ack_q, ack_d;
    logic [DATA_BITS-1:0] rdata_q [3];
    logic [DATA_BITS-1:0] rdata_d [3];

    logic       ref_pending, ref_urgent, ref_done;
    logic       grant_vld;
    sdram_ch_t  grant_ch;
    sdram_cmd_t grant_cmd;

    sdram_arbiter_refresh_scheduler #(
        .REFRESH_INT (REFRESH_INT),
        .DEBT_MAX    (DEBT_MAX)
    ) u_refresh (
        .clk     (clk),
        .reset   (reset),
        .done    (ref_done),
        .debt    (refresh_debt),
        .pending (ref_pending),
        .urgent  (ref_urgent)
    );

    // Refresh with a CPU idle hint slots in ahead of HOST; otherwise HOST only yields to real demand.
    always_comb begin
        grant_vld = 1'b1;
        grant_ch  = CH_REF;
        if (ref_urgent)                       grant_ch = CH_REF;
        else if (prg_req)                     grant_ch = CH_PRG;
        else if (chr_req)                     grant_ch = CH_CHR;
        else if (ref_pending && refresh_hint) grant_ch = CH_REF;
        else if (host_req)                    grant_ch = CH_HOST;
        else if (ref_pending)                 grant_ch = CH_REF;
        else                                  grant_vld = 1'b0;

        grant_cmd         = '0;
        grant_cmd.refresh = (grant_ch == CH_REF);
        case (grant_ch)
            CH_PRG:  grant_cmd = '{refresh: 1'b0, we: prg_we, addr: prg_addr,
                                   wdata: prg_wdata, wmask: prg_wmask};
            CH_CHR:  grant_cmd = '{refresh: 1'b0, we: chr_we, addr: chr_addr,
                                   wdata: chr_wdata, wmask: chr_wmask};
            CH_HOST: grant_cmd = '{refresh: 1'b0, we: host_we, addr: host_addr,
                                   wdata: host_wdata, wmask: host_wmask};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        ack_d    = 3'b000;
        rdata_d  = rdata_q;
        ref_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_ISSUE;
                    owner_d = grant_ch;
                    cmd_d   = grant_cmd;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_d  = ST_DONE;
                    ref_done = (owner_q == CH_REF);
                    for (int i = 0; i < 3; i++) begin
                        if (owner_q == sdram_ch_t'(2'(i))) begin
                            ack_d[i] = 1'b1;
                            if (!cmd_q.we) rdata_d[i] = rsp_rdata;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= CH_PRG;
            cmd_q   <= '0;
            ack_q   <= 3'b000;
            for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_refresh = cmd_q.refresh;
    assign cmd_we      = cmd_q.we;
    assign cmd_addr    = cmd_q.addr;
    assign cmd_wdata   = cmd_q.wdata;
    assign cmd_wmask   = cmd_q.wmask;

    assign prg_ack    = ack_q[0];
    assign chr_ack    = ack_q[1];
    assign host_ack   = ack_q[2];
    assign prg_rdata  = rdata_q[0];
    assign chr_rdata  = rdata_q[1];
    assign host_rdata = rdata_q[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: a transaction-level reference predicts every command
// and ack; a negedge monitor compares the DUT against the expectation queues.
module tb_sdram_arbiter;

    localparam int REF_INT  = 16;
    localparam int DEBT_MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_v = 3'b000;
    logic [22:0] addr_v  [3];
    logic        we_v    [3];
    logic [15:0] wdata_v [3];
    logic [1:0]  wmask_v [3];
    logic        refresh_hint = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_rdata = 16'h0;

    logic        prg_ack, chr_ack, host_ack;
    logic [15:0] prg_rdata, chr_rdata, host_rdata;
    logic        cmd_valid, cmd_refresh, cmd_we;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_wmask;
    logic [3:0]  refresh_debt;
    wire  [2:0]  ack_w = {host_ack, chr_ack, prg_ack};

    always #5 clk = ~clk;

    sdram_arbiter #(.REFRESH_INT(REF_INT), .DEBT_MAX(DEBT_MAX)) dut (
        .clk(clk), .reset(reset),
        .prg_req(req_v[0]), .prg_addr(addr_v[0]), .prg_we(we_v[0]),
        .prg_wdata(wdata_v[0]), .prg_wmask(wmask_v[0]), .prg_ack(prg_ack), .prg_rdata(prg_rdata),
        .chr_req(req_v[1]), .chr_addr(addr_v[1]), .chr_we(we_v[1]),
        .chr_wdata(wdata_v[1]), .chr_wmask(wmask_v[1]), .chr_ack(chr_ack), .chr_rdata(chr_rdata),
        .host_req(req_v[2]), .host_addr(addr_v[2]), .host_we(we_v[2]),
        .host_wdata(wdata_v[2]), .host_wmask(wmask_v[2]), .host_ack(host_ack), .host_rdata(host_rdata),
        .refresh_hint(refresh_hint),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_refresh(cmd_refresh),
        .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .refresh_debt(refresh_debt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          refresh;
        bit          we;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
    } exp_cmd_t;
    typedef struct {
        int ch;
    } exp_ack_t;

    exp_cmd_t    cmd_q[$];
    exp_ack_t    ack_q[$];
    int          m_phase = 0;   // 0 free, 1 offered, 2 accepted, 3 completing
    int          m_ch = 0;
    bit          m_we = 0;
    int          m_debt = 0;
    int          m_cyc = 0;
    logic [15:0] m_rdata [3] = '{16'h0, 16'h0, 16'h0};

    function automatic int pick(input logic [2:0] r, input logic h, input int d);
        if (d == DEBT_MAX) return 3;
        if (r[0]) return 0;
        if (r[1]) return 1;
        if (d > 0 && h) return 3;
        if (r[2]) return 2;
        if (d > 0) return 3;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_debt = 0; m_cyc = 0;
            m_rdata = '{16'h0, 16'h0, 16'h0};
            cmd_q.delete(); ack_q.delete();
        end else begin
            bit refreshed;
            int w;
            exp_cmd_t e;
            refreshed = 0;
            case (m_phase)
                0: begin
                    w = pick(req_v, refresh_hint, m_debt);
                    if (w >= 0) begin
                        e = '{refresh: (w == 3), we: 0, addr: '0, wdata: '0, wmask: '0};
                        if (w < 3) e = '{refresh: 0, we: we_v[w], addr: addr_v[w],
                                         wdata: wdata_v[w], wmask: wmask_v[w]};
                        cmd_q.push_back(e);
                        m_ch = w; m_we = e.we; m_phase = 1;
                    end
                end
                1: if (cmd_ready) m_phase = 2;
                2: if (rsp_valid) begin
                    if (m_ch == 3) refreshed = 1;
                    else begin
                        if (!m_we) m_rdata[m_ch] = rsp_rdata;
                        ack_q.push_back('{ch: m_ch});
                    end
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
            m_cyc++;
            if ((m_cyc % REF_INT) == 0 && !refreshed) m_debt = (m_debt < DEBT_MAX) ? m_debt + 1 : DEBT_MAX;
            else if ((m_cyc % REF_INT) != 0 && refreshed) m_debt = (m_debt > 0) ? m_debt - 1 : 0;
        end
    end

    // ---------------- monitor ----------------
    bit       prev_cv = 0;
    exp_cmd_t cur;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_cmd_valid", 32'(cmd_valid), 0);
            chk("rst_cmd_refresh", 32'(cmd_refresh), 0);
            chk("rst_ack", 32'(ack_w), 0);
            chk("rst_debt", 32'(refresh_debt), 0);
            chk("rst_rdata", {prg_rdata, chr_rdata | host_rdata}, 0);
            prev_cv = 0;
        end else begin
            if (cmd_q.size() != 0) begin
                cur = cmd_q.pop_front();
                chk("cmd_start", 32'(cmd_valid && !prev_cv), 1);
                chk("cmd_refresh", 32'(cmd_refresh), 32'(cur.refresh));
                if (!cur.refresh) begin
                    chk("cmd_addr", 32'(cmd_addr), 32'(cur.addr));
                    chk("cmd_we", 32'(cmd_we), 32'(cur.we));
                    if (cur.we) chk("cmd_wdata", {14'd0, cmd_wmask, cmd_wdata}, {14'd0, cur.wmask, cur.wdata});
                end
            end else begin
                chk("cmd_unexpected", 32'(cmd_valid && !prev_cv), 0);
                if (cmd_valid && !cur.refresh) chk("cmd_stable", 32'(cmd_addr), 32'(cur.addr));
            end
            prev_cv = cmd_valid;
            if (ack_q.size() != 0) chk("ack_vec", 32'(ack_w), 32'(1) << ack_q.pop_front().ch);
            else chk("ack_idle", 32'(ack_w), 0);
            chk("prg_rdata", 32'(prg_rdata), 32'(m_rdata[0]));
            chk("chr_rdata", 32'(chr_rdata), 32'(m_rdata[1]));
            chk("host_rdata", 32'(host_rdata), 32'(m_rdata[2]));
            chk("debt", 32'(refresh_debt), 32'(m_debt));
        end
    end

    // ---------------- stimulus ----------------
    bit          rnd_en = 0, ctl_stall = 0, ctl_always_ready = 0, ctl_data_fix = 0, ctl_busy = 0;
    int          ctl_lat = -1, ctl_cnt = 0;
    logic [15:0] ctl_data = 16'h0;

    task automatic ctl_tick();
        rsp_valid = 1'b0;
        cmd_ready = 1'b0;
        if (reset) ctl_busy = 0;
        else if (ctl_busy) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_rdata = ctl_data_fix ? ctl_data : 16'($urandom);
                ctl_busy  = 0;
            end
        end else if (cmd_valid && !ctl_stall && (ctl_always_ready || $urandom_range(2) != 0)) begin
            cmd_ready = 1'b1;
            ctl_busy  = 1;
            ctl_cnt   = ((ctl_lat < 0) ? int'($urandom_range(4)) : ctl_lat) + 1;
        end
    endtask

    task automatic raise(input int i, input logic [22:0] a, input logic w);
        req_v[i] = 1'b1; addr_v[i] = a; we_v[i] = w;
        wdata_v[i] = 16'($urandom); wmask_v[i] = 2'($urandom);
    endtask

    // Inputs change 1 time unit after the falling edge; reads here are away from the active edge.
    task automatic step();
        @(negedge clk);
        #1;
        ctl_tick();
        if (rnd_en) begin
            for (int i = 0; i < 3; i++) begin
                if (req_v[i]) begin
                    if (ack_w[i] || $urandom_range(63) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(7) == 0) begin
                    raise(i, 23'($urandom), 1'($urandom));
                end
            end
            refresh_hint = ($urandom_range(3) == 0);
        end else begin
            refresh_hint = 1'b0;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at, n_ack;
        int order [3];
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = '0; we_v[i] = 1'b0; wdata_v[i] = '0; wmask_v[i] = '0;
        end
        repeat (3) step();

        // Single PRG read, controller answers 4 cycles into WAIT.
        ctl_lat = 4; ctl_data_fix = 1; ctl_data = 16'hBEEF; ctl_always_ready = 1;
        reset = 1'b0;
        raise(0, 23'h000123, 1'b0);
        ack_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                chk("prg_first_valid", 32'(cmd_valid), 1);
                chk("prg_first_addr", 32'(cmd_addr), 32'h000123);
            end
            if (prg_ack) begin
                if (ack_at == 0) ack_at = k;
                chk("prg_first_rdata", 32'(prg_rdata), 32'hBEEF);
                req_v[0] = 1'b0;
            end
        end
        chk("prg_ack_cycle", 32'(ack_at), 7);

        // All three request together: PRG, CHR, HOST in that order.
        ctl_lat = -1; ctl_data_fix = 0;
        raise(0, 23'h1000, 1'b0); raise(1, 23'h2000, 1'b1); raise(2, 23'h3000, 1'b0);
        n_ack = 0;
        for (int k = 0; k < 80 && n_ack < 3; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (ack_w[i]) begin
                    order[n_ack] = i;
                    n_ack++;
                    req_v[i] = 1'b0;
                end
            end
        end
        chk("all3_ack_count", 32'(n_ack), 3);
        if (n_ack == 3) begin
            chk("all3_first", 32'(order[0]), 0);
            chk("all3_second", 32'(order[1]), 1);
            chk("all3_third", 32'(order[2]), 2);
        end
        repeat (5) step();

        // Reset while the PRG read is in WAIT, then a stray response.
        reset = 1'b1; step(); reset = 1'b0;
        ctl_lat = 10; ctl_data_fix = 1; ctl_data = 16'h1234;
        raise(0, 23'h000456, 1'b0);
        repeat (3) step();
        reset = 1'b1; req_v[0] = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        rsp_valid = 1'b1; rsp_rdata = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stray_no_ack", 32'(ack_w), 0);
            chk("stray_idle", 32'(cmd_valid), 0);
        end
        ctl_lat = 2;
        raise(0, 23'h000789, 1'b0);
        ack_at = 0;
        for (int k = 1; k <= 30 && ack_at == 0; k++) begin
            step();
            if (prg_ack) begin
                ack_at = k;
                req_v[0] = 1'b0;
                chk("post_reset_rdata", 32'(prg_rdata), 32'h1234);
            end
        end
        chk("post_reset_acked", 32'(ack_at != 0), 1);

        // Random traffic with long controller stalls to drive debt to saturation.
        ctl_lat = -1; ctl_data_fix = 0; ctl_always_ready = 0; rnd_en = 1;
        for (int blk = 0; blk < 6; blk++) begin
            repeat (500) step();
            ctl_stall = 1;
            repeat (150) step();
            chk("stall_debt_sat", 32'(refresh_debt), DEBT_MAX);
            ctl_stall = 0;
        end

        // Quiet tail: only periodic refresh remains.
        rnd_en = 0;
        req_v = 3'b000;
        repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
